mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: word-address width; array depth is 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter LATENCY, default 2: read wait cycles, legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 PC  input  32  instruction fetch byte address.
REQ-006 Inst_Req_Valid  input  1; Inst_Req_Ready  output  1: instruction request handshake.
REQ-007 Instruction  output  32; Inst_Valid  output  1; Inst_Ready  input  1: instruction response handshake.
REQ-008 Address  input  32; MemRead  input  1; MemWrite  input  1; Write_data  input  32; Write_strb  input  4; Mem_Req_Ready  output  1: data request.
REQ-009 Read_data  output  32; Read_data_Valid  output  1; Read_data_Ready  input  1: data read response.

Function
REQ-010 The FSM SHALL have states IDLE, WAIT, IRESP and DRESP, one-hot encoded.
REQ-011 In IDLE with rst high: Mem_Req_Ready=1; Inst_Req_Ready=1 only if MemRead=0 and MemWrite=0. Both SHALL be 0 in all other states.
REQ-012 A data request SHALL win over a same-cycle instruction request; the losing request is not accepted and must be held by the initiator.
REQ-013 Word index = addr[ADDR_WIDTH+1:2]; addr[1:0] and bits above SHALL be ignored, so out-of-range addresses wrap.
REQ-014 Write: MemWrite && Mem_Req_Ready at a posedge SHALL update byte lane i iff Write_strb[i] is set, at that edge. Write_strb=0 writes nothing. There is no response, and the FSM stays in IDLE.
REQ-015 If MemRead and MemWrite are both 1, the request SHALL be handled as a write only.
REQ-016 Read accept (MemRead, or an instruction request, with ready=1 at a posedge) SHALL capture the array word into the response register at that edge. The FSM goes to WAIT with a 4-bit counter = LATENCY, or straight to IRESP/DRESP if LATENCY=0.
REQ-017 WAIT SHALL decrement the counter each cycle. When the counter is 1, the next state is IRESP or DRESP, by request source.
REQ-018 Valid (Inst_Valid in IRESP, Read_data_Valid in DRESP) SHALL first be high exactly LATENCY+1 cycles after the accept edge.
REQ-019 Valid and data SHALL stay stable until the matching Ready is 1 at a posedge; the FSM then returns to IDLE.
REQ-020 The earliest next accept SHALL be the cycle after returning to IDLE, so back-to-back reads have a minimum period of LATENCY+2 cycles.
REQ-021 Ready inputs asserted before Valid SHALL have no effect. Instruction/Read_data SHALL hold their last value after the handshake.
REQ-022 A write immediately followed by a read of the same word SHALL return the newly written data.

Reset
REQ-023 rst low SHALL immediately force IDLE, counter 0, Instruction=0, Read_data=0, all Valid=0 and all Ready=0.
REQ-024 Reset mid-operation SHALL discard any pending response. A write coinciding with reset assertion SHALL NOT be performed.
REQ-025 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-026 With MEM_RESP_STALL_EN defined, an 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) SHALL advance every cycle.
REQ-027 With MEM_RESP_STALL_EN defined, both request Readys SHALL additionally be ANDed with lfsr[0], giving deterministic pseudo-random request stalls.
REQ-028 Without MEM_RESP_STALL_EN, no LFSR SHALL exist and REQ-011 applies unmodified.

Verification
REQ-029 LATENCY=2: write 32'hDEADBEEF strb 4'hF to 0x10, then read 0x10 with Read_data_Ready=1 -> Read_data_Valid high 3 cycles after accept, Read_data=32'hDEADBEEF.
REQ-030 Write 32'h000000AA strb 4'b0100 to 0x10 over the REQ-029 data -> later read returns 32'hDEAABEEF.
REQ-031 Same-cycle MemRead at 0x0 and Inst_Req_Valid at PC=0x4 -> only Mem_Req_Ready=1; the instruction is accepted after the data handshake completes.
REQ-032 Hold Inst_Ready=0 for 5 cycles after Inst_Valid -> Instruction stable, no new accept; Inst_Ready=1 -> IDLE the next cycle.
REQ-033 With ADDR_WIDTH=12, read 0x4010 -> returns the word at 0x0010. With LATENCY=0 -> valid 1 cycle after accept.
REQ-034 Assert rst during WAIT -> all Valid and Ready 0 immediately; after release, a new read is accepted normally and the stale response never appears.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory that serves instruction fetches and data
// reads/writes. Reads return after a fixed latency through valid/ready response
// handshakes; writes complete at the accept edge and produce no response.
// Build option: define MEM_RESP_STALL_EN to gate the request readys with an 8-bit LFSR,
// which gives deterministic pseudo-random request stalls.
`timescale 1ns/1ps
module mem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction fetch port
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  // Data port
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready
);

  localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  LatCnt = 4'(LATENCY);

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StWait  = 4'b0010,
    StIResp = 4'b0100,
    StDResp = 4'b1000
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    src_inst_q, src_inst_d;  // 1: pending read came from the fetch port
  logic [31:0]             inst_q;
  logic [31:0]             rdata_q;
  logic [31:0]             mem_q [Depth];

  logic                    req_gate;
  logic                    idle_rdy;
  logic                    wr_en;
  logic                    d_rd_acc;
  logic                    i_rd_acc;
  logic [ADDR_WIDTH-1:0]   d_idx;
  logic [ADDR_WIDTH-1:0]   i_idx;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic [31:0]             rd_word;
  logic [1:0]              strb_off;
  logic [31:0]             wdata_al;
  logic                    unused_addr_bits;

`ifdef MEM_RESP_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4, free-running every cycle
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign req_gate = lfsr_q[0];
`else
  assign req_gate = 1'b1;
`endif

  // Word index ignores the byte offset and any address bits above the array
  assign d_idx  = Address[ADDR_WIDTH+1:2];
  assign i_idx  = PC[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0],
                              Address[31:ADDR_WIDTH+2], Address[1:0]};

  // Request readys and accept decode; a data request always wins over a fetch
  always_comb begin
    idle_rdy       = (state_q == StIdle) && rst && req_gate;
    Mem_Req_Ready  = idle_rdy;
    Inst_Req_Ready = idle_rdy && !MemRead && !MemWrite;
    wr_en          = MemWrite && Mem_Req_Ready;
    d_rd_acc       = MemRead && !MemWrite && Mem_Req_Ready;
    i_rd_acc       = Inst_Req_Valid && Inst_Req_Ready;
    rd_idx         = d_rd_acc ? d_idx : i_idx;
    rd_word        = mem_q[rd_idx];
  end

  // Write_data is right-aligned: its low byte lands in the lowest enabled lane
  always_comb begin
    if (Write_strb[0]) begin
      strb_off = 2'd0;
    end else if (Write_strb[1]) begin
      strb_off = 2'd1;
    end else if (Write_strb[2]) begin
      strb_off = 2'd2;
    end else begin
      strb_off = 2'd3;
    end
    wdata_al = Write_data << {strb_off, 3'b000};
  end

  // FSM next state and wait counter
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_inst_d = src_inst_q;
    unique case (state_q)
      StIdle: begin
        if (d_rd_acc || i_rd_acc) begin
          src_inst_d = i_rd_acc;
          if (LATENCY == 0) begin
            cnt_d   = 4'd0;
            state_d = i_rd_acc ? StIResp : StDResp;
          end else begin
            cnt_d   = LatCnt;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = src_inst_q ? StIResp : StDResp;
        end
      end
      StIResp: begin
        if (Inst_Ready) begin
          state_d = StIdle;
        end
      end
      StDResp: begin
        if (Read_data_Ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      src_inst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_inst_q <= src_inst_d;
    end
  end

  // Response registers capture the array word at the accept edge and hold afterwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q  <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      if (i_rd_acc) begin
        inst_q <= rd_word;
      end
      if (d_rd_acc) begin
        rdata_q <= rd_word;
      end
    end
  end

  // Byte-lane writes; the array is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (Write_strb[i]) begin
          mem_q[d_idx][8*i +: 8] <= wdata_al[8*i +: 8];
        end
      end
    end
  end

  // Response outputs
  always_comb begin
    Inst_Valid      = (state_q == StIResp);
    Read_data_Valid = (state_q == StDResp);
    Instruction     = inst_q;
    Read_data       = rdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a reference word memory predicts read data,
// expectations are queued at issue and checked when the response handshake happens.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int unsigned AW  = 12;
  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC = '0;
  logic        Inst_Req_Valid = 1'b0;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready = 1'b1;
  logic [31:0] Address = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Write_data = '0;
  logic [3:0]  Write_strb = '0;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready = 1'b1;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .PC              (PC),
    .Inst_Req_Valid  (Inst_Req_Valid),
    .Inst_Req_Ready  (Inst_Req_Ready),
    .Instruction     (Instruction),
    .Inst_Valid      (Inst_Valid),
    .Inst_Ready      (Inst_Ready),
    .Address         (Address),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .Mem_Req_Ready   (Mem_Req_Ready),
    .Read_data       (Read_data),
    .Read_data_Valid (Read_data_Valid),
    .Read_data_Ready (Read_data_Ready)
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] dq [$];
  logic [31:0] iq [$];
  logic [31:0] model [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    if (model.exists(widx(a))) return model[widx(a)];
    return 32'h0;
  endfunction

  // Reference write: data byte 0 goes to the lowest enabled lane, then upward
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    int off;
    w   = model_word(a);
    off = 0;
    for (int i = 3; i >= 0; i--) if (s[i]) off = i;
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*(i-off) +: 8];
    model[widx(a)] = w;
  endtask

  // Response monitor: samples mid-cycle what the next posedge will see
  always begin
    @(negedge clk);
    #2;
    if (rst && Read_data_Valid && Read_data_Ready) begin
      if (dq.size() == 0) check("rd_unexpected", {31'b0, Read_data_Valid}, 32'd0);
      else check("rd_data", Read_data, dq.pop_front());
    end
    if (rst && Inst_Valid && Inst_Ready) begin
      if (iq.size() == 0) check("if_unexpected", {31'b0, Inst_Valid}, 32'd0);
      else check("if_data", Instruction, iq.pop_front());
    end
  end

  // Called just after a negedge with request inputs set; returns 1ns after the accept edge
  task automatic wait_accept(input bit is_data, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (is_data ? Mem_Req_Ready : Inst_Req_Ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain(input bit is_data);
    for (int k = 0; k < 40; k++) begin
      if ((is_data ? dq.size() : iq.size()) == 0) break;
      @(negedge clk);
    end
    check(is_data ? "rd_drain" : "if_drain", 32'(is_data ? dq.size() : iq.size()), 32'd0);
  endtask

  task automatic rd_response(input logic [31:0] exp);
    int lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (Read_data_Valid) begin
        lat = n;
        break;
      end
    end
    check("rd_latency", 32'(lat), 32'(LAT + 1));
    drain(1'b1);
    check("rd_hold", Read_data, exp);
    check("rd_valid_low", {31'b0, Read_data_Valid}, 32'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok;
    @(negedge clk);
    Address = a; Write_data = d; Write_strb = s; MemWrite = 1'b1;
    wait_accept(1'b1, ok);
    MemWrite = 1'b0; Write_strb = 4'h0;
    check("wr_accept", {31'b0, ok}, 32'd1);
    if (ok) model_write(a, d, s);
    @(negedge clk);
    #1;
    check("wr_stays_idle", {31'b0, Mem_Req_Ready}, 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a);
    bit ok;
    logic [31:0] exp;
    @(negedge clk);
    Address = a; MemRead = 1'b1; Read_data_Ready = 1'b1;
    exp = model_word(a);
    dq.push_back(exp);
    wait_accept(1'b1, ok);
    MemRead = 1'b0;
    check("rd_accept", {31'b0, ok}, 32'd1);
    if (!ok) begin
      dq.delete(dq.size() - 1);
      return;
    end
    rd_response(exp);
  endtask

  task automatic do_fetch(input logic [31:0] pc, input int hold);
    bit ok;
    int lat;
    logic [31:0] exp;
    @(negedge clk);
    PC = pc; Inst_Req_Valid = 1'b1; Inst_Ready = (hold == 0);
    exp = model_word(pc);
    iq.push_back(exp);
    wait_accept(1'b0, ok);
    Inst_Req_Valid = 1'b0;
    check("if_accept", {31'b0, ok}, 32'd1);
    if (!ok) begin
      iq.delete(iq.size() - 1);
      Inst_Ready = 1'b1;
      return;
    end
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (Inst_Valid) begin
        lat = n;
        break;
      end
    end
    check("if_latency", 32'(lat), 32'(LAT + 1));
    if (hold > 0) begin
      // Stall the response while offering another fetch that must not be taken
      Inst_Req_Valid = 1'b1; PC = pc + 32'd4;
      for (int h = 0; h < hold; h++) begin
        #1;
        check("if_stable", Instruction, exp);
        check("if_valid_held", {31'b0, Inst_Valid}, 32'd1);
        check("if_no_accept", {31'b0, Inst_Req_Ready}, 32'd0);
        @(negedge clk);
      end
      Inst_Req_Valid = 1'b0;
      Inst_Ready = 1'b1;
    end
    drain(1'b0);
    check("if_idle_rdy", {31'b0, Inst_Req_Ready}, 32'd1);
    check("if_hold", Instruction, exp);
    check("if_valid_low", {31'b0, Inst_Valid}, 32'd0);
    Inst_Ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [31:0] exp;

    // Reset state
    #12;
    check("rst_mem_rdy", {31'b0, Mem_Req_Ready}, 32'd0);
    check("rst_inst_rdy", {31'b0, Inst_Req_Ready}, 32'd0);
    check("rst_rd_valid", {31'b0, Read_data_Valid}, 32'd0);
    check("rst_if_valid", {31'b0, Inst_Valid}, 32'd0);
    check("rst_rdata", Read_data, 32'd0);
    check("rst_inst", Instruction, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("idle_mem_rdy", {31'b0, Mem_Req_Ready}, 32'd1);
    check("idle_inst_rdy", {31'b0, Inst_Req_Ready}, 32'd1);

    // Full write then read, then partial-strobe and zero-strobe writes
    do_write(32'h10, 32'hDEADBEEF, 4'hF);
    do_read(32'h10);
    do_write(32'h10, 32'h000000AA, 4'b0100);
    do_read(32'h10);
    check("strb_lane2", model_word(32'h10), 32'hDEAABEEF);
    do_write(32'h10, 32'hFFFFFFFF, 4'h0);
    do_read(32'h10);
    do_write(32'h14, 32'h0000BEAD, 4'b0011);
    do_read(32'h14);

    // Address wrap and ignored byte offset
    do_read(32'h4010);
    do_read(32'h13);

    // MemRead+MemWrite together is a write; a read of the same word follows at once
    @(negedge clk);
    Address = 32'h20; Write_data = 32'h12345678; Write_strb = 4'hF;
    MemRead = 1'b1; MemWrite = 1'b1;
    wait_accept(1'b1, ok);
    check("both_accept", {31'b0, ok}, 32'd1);
    if (ok) model_write(32'h20, 32'h12345678, 4'hF);
    MemWrite = 1'b0; Write_strb = 4'h0; Write_data = 32'h0;
    check("both_stays_idle", {31'b0, Mem_Req_Ready}, 32'd1);
    exp = model_word(32'h20);
    dq.push_back(exp);
    wait_accept(1'b1, ok);
    MemRead = 1'b0;
    check("raw_accept", {31'b0, ok}, 32'd1);
    rd_response(exp);

    // Instruction fetches, including a stalled response
    do_write(32'h0, 32'h11223344, 4'hF);
    do_write(32'h4, 32'h00500093, 4'hF);
    do_write(32'h8, 32'h00A00113, 4'hF);
    do_fetch(32'h4, 0);
    do_fetch(32'h8, 5);

    // Same-cycle data read and fetch: data wins, fetch is taken after the data handshake
    @(negedge clk);
    Address = 32'h0; MemRead = 1'b1; PC = 32'h4; Inst_Req_Valid = 1'b1;
    dq.push_back(model_word(32'h0));
    iq.push_back(model_word(32'h4));
    #1;
    check("contend_mem_rdy", {31'b0, Mem_Req_Ready}, 32'd1);
    check("contend_inst_rdy", {31'b0, Inst_Req_Ready}, 32'd0);
    @(posedge clk);
    #1;
    MemRead = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (dq.size() == 0) break;
      check("inst_blocked", {31'b0, Inst_Req_Ready}, 32'd0);
    end
    check("contend_rd_done", 32'(dq.size()), 32'd0);
    check("inst_after_data", {31'b0, Inst_Req_Ready}, 32'd1);
    @(posedge clk);
    #1;
    Inst_Req_Valid = 1'b0;
    drain(1'b0);
    check("contend_inst", Instruction, model_word(32'h4));

    // Reset while a read is waiting: response is discarded, array survives
    do_write(32'h30, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    Address = 32'h10; MemRead = 1'b1;
    wait_accept(1'b1, ok);
    MemRead = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_rd_valid", {31'b0, Read_data_Valid}, 32'd0);
    check("mid_rst_if_valid", {31'b0, Inst_Valid}, 32'd0);
    check("mid_rst_mem_rdy", {31'b0, Mem_Req_Ready}, 32'd0);
    check("mid_rst_inst_rdy", {31'b0, Inst_Req_Ready}, 32'd0);
    check("mid_rst_rdata", Read_data, 32'd0);
    check("mid_rst_inst", Instruction, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_read(32'h30);
    do_read(32'h10);
    repeat (6) @(negedge clk);
    check("no_stale_resp", {31'b0, Read_data_Valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
